// File: rtl/otl_dac_pkg.sv
// Shared state encoding and address step for the DAC DMA-to-FIFO streaming engine.
package otl_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dac_state_e;

  localparam int unsigned DAC_DATAW = 32;
  localparam int unsigned ADDR_INC  = DAC_DATAW / 8;

endpackage

// File: rtl/otl_dac_reqgen.sv
// Read-request generator: window address/remaining counters, registered request
// valid with hold-until-ready, and circular wrap back to the window base.
module otl_dac_reqgen
  import otl_dac_pkg::*;
#(
  parameter int unsigned ADDRW = 32,
  parameter int unsigned LENW  = 16,
  parameter int unsigned STEP  = ADDR_INC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [ADDRW-1:0] i_cfg_base,
  input  logic [LENW-1:0]  i_cfg_len,
  input  logic             i_cfg_circular,
  input  logic             i_issue_ok,
  input  logic             i_rdready,
  output logic [ADDRW-1:0] o_rdaddr,
  output logic             o_rdvalid,
  output logic             o_accept,
  output logic             o_exhausted
);

  logic [ADDRW-1:0] r_base;
  logic [ADDRW-1:0] r_addr;
  logic [ADDRW-1:0] w_addr_next;
  logic [LENW-1:0]  r_len;
  logic [LENW-1:0]  r_rem;
  logic [LENW-1:0]  w_rem_next;
  logic             r_circ;
  logic             r_valid;
  logic             w_wrap;

  assign o_accept = r_valid && i_rdready;
  assign w_wrap   = o_accept && r_circ && (r_rem == LENW'(1));

  always_comb begin
    w_addr_next = r_addr;
    w_rem_next  = r_rem;
    if (i_start) begin
      w_addr_next = i_cfg_base;
      w_rem_next  = i_cfg_len;
    end else if (w_wrap) begin
      w_addr_next = r_base;
      w_rem_next  = r_len;
    end else if (o_accept) begin
      w_addr_next = r_addr + ADDRW'(STEP);
      w_rem_next  = r_rem - LENW'(1);
    end
  end

  assign o_exhausted = (w_rem_next == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_len   <= '0;
      r_circ  <= 1'b0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_addr <= w_addr_next;
      r_rem  <= w_rem_next;
      if (i_start) begin
        r_base <= i_cfg_base;
        r_len  <= i_cfg_len;
        r_circ <= i_cfg_circular;
      end
      // A pending request is never withdrawn; otherwise re-evaluate on the next word.
      if (r_valid && !i_rdready) r_valid <= 1'b1;
      else                       r_valid <= i_issue_ok && !o_exhausted;
    end
  end

  assign o_rdaddr  = r_addr;
  assign o_rdvalid = r_valid;

endmodule

// File: rtl/otl_dac_core.sv
// DMA-read to FIFO-write streaming engine for the DAC path: bounded outstanding
// reads over a linear or circular window, responses registered into the sample FIFO.
module otl_dac_core
  import otl_dac_pkg::*;
#(
  parameter int unsigned ADDRW   = 32,
  parameter int unsigned DATAW   = DAC_DATAW,
  parameter int unsigned LENW    = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [ADDRW-1:0] cfg_base,
  input  logic [LENW-1:0]  cfg_len,
  input  logic             cfg_circular,
  output logic [ADDRW-1:0] dma_rdaddr,
  output logic             dma_rdvalid,
  input  logic             dma_rdready,
  input  logic [DATAW-1:0] dma_rddata,
  input  logic             dma_rddvalid,
  output logic [DATAW-1:0] fifo_wrdata,
  output logic             fifo_wren,
  input  logic             fifo_full,
  input  logic             fifo_afull,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int unsigned OUTW = $clog2(MAX_OUT + 1);

  dac_state_e       r_state;
  logic [OUTW-1:0]  r_out;
  logic [OUTW-1:0]  w_out_next;
  logic             r_abort;
  logic             r_wren;
  logic [DATAW-1:0] r_wrdata;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic             w_start;
  logic             w_resp;
  logic             w_issue_ok;
  logic             w_accept;
  logic             w_exhausted;
  logic             w_rdvalid;
  logic [ADDRW-1:0] w_rdaddr;

  assign w_start = (r_state == ST_IDLE) && enable && (cfg_len != '0);
  assign w_resp  = dma_rddvalid && (r_out != '0);

  always_comb begin
    w_out_next = r_out;
    if (w_accept && !w_resp)      w_out_next = r_out + OUTW'(1);
    else if (!w_accept && w_resp) w_out_next = r_out - OUTW'(1);
  end

  // Budget uses the post-edge count so a freshly raised request never exceeds MAX_OUT.
  assign w_issue_ok = (w_start || (r_state == ST_RUN)) && enable && !fifo_afull &&
                      (w_out_next < OUTW'(MAX_OUT));

  otl_dac_reqgen #(
    .ADDRW (ADDRW),
    .LENW  (LENW),
    .STEP  (DATAW / 8)
  ) u_reqgen (
    .clk            (clk),
    .reset          (reset),
    .i_start        (w_start),
    .i_cfg_base     (cfg_base),
    .i_cfg_len      (cfg_len),
    .i_cfg_circular (cfg_circular),
    .i_issue_ok     (w_issue_ok),
    .i_rdready      (dma_rdready),
    .o_rdaddr       (w_rdaddr),
    .o_rdvalid      (w_rdvalid),
    .o_accept       (w_accept),
    .o_exhausted    (w_exhausted)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_out    <= '0;
      r_abort  <= 1'b0;
      r_wren   <= 1'b0;
      r_wrdata <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_out  <= w_out_next;
      r_wren <= w_resp;
      r_done <= 1'b0;
      if (w_resp) r_wrdata <= dma_rddata;
      if (w_resp && fifo_full) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_busy <= 1'b1;
            if (cfg_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_abort <= 1'b0;
              r_ovf   <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (w_exhausted) begin
            r_state <= ST_DRAIN;
            r_abort <= 1'b0;
          end else if (!enable && !(w_rdvalid && !dma_rdready)) begin
            r_state <= ST_DRAIN;
            r_abort <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_out == '0) begin
            if (r_abort) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dma_rdaddr  = w_rdaddr;
  assign dma_rdvalid = w_rdvalid;
  assign fifo_wren   = r_wren;
  assign fifo_wrdata = r_wrdata;
  assign busy        = r_busy;
  assign done        = r_done;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_otl_dac_core.sv
// Directed bench for otl_dac_core: table of linear transfers plus hand-written
// sequences for the outstanding limit, circular wrap, backpressure, abort and reset.
module tb_otl_dac_core;

  localparam int MAX_OUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] cfg_base;
  logic [15:0] cfg_len;
  logic        cfg_circular;
  logic [31:0] dma_rdaddr;
  logic        dma_rdvalid;
  logic        dma_rdready;
  logic [31:0] dma_rddata;
  logic        dma_rddvalid;
  logic [31:0] fifo_wrdata;
  logic        fifo_wren;
  logic        fifo_full;
  logic        fifo_afull;
  logic        busy;
  logic        done;
  logic        overflow;

  otl_dac_core #(
    .ADDRW   (32),
    .DATAW   (32),
    .LENW    (16),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_base     (cfg_base),
    .cfg_len      (cfg_len),
    .cfg_circular (cfg_circular),
    .dma_rdaddr   (dma_rdaddr),
    .dma_rdvalid  (dma_rdvalid),
    .dma_rdready  (dma_rdready),
    .dma_rddata   (dma_rddata),
    .dma_rddvalid (dma_rddvalid),
    .fifo_wrdata  (fifo_wrdata),
    .fifo_wren    (fifo_wren),
    .fifo_full    (fifo_full),
    .fifo_afull   (fifo_afull),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int model_out = 0;
  int n_acc = 0;
  int n_wr = 0;
  int n_done = 0;
  int resp_lat = 3;
  int resp_budget = 1000000;
  logic [31:0] rec_addr[$];
  int          pend_due[$];
  logic [31:0] pend_data[$];

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    int          lat;
    logic [31:0] last;
  } vec_t;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: record accepts, model outstanding/FIFO writes, check hold, drive responses.
  task automatic tick();
    logic        acc;
    logic        exp_wr;
    logic        pend_hold;
    logic [31:0] exp_data;
    logic [31:0] hold_addr;
    acc       = dma_rdvalid && dma_rdready && !reset;
    pend_hold = dma_rdvalid && !dma_rdready && !reset;
    hold_addr = dma_rdaddr;
    exp_wr    = dma_rddvalid && (model_out > 0) && !reset;
    exp_data  = dma_rddata;
    if (acc) begin
      chk("out_limit", 64'(model_out < MAX_OUT), 64'd1);
      rec_addr.push_back(dma_rdaddr);
      pend_due.push_back(cyc + resp_lat);
      pend_data.push_back(data_of(dma_rdaddr));
      n_acc++;
    end
    if (reset) model_out = 0;
    else       model_out = model_out + (acc ? 1 : 0) - (exp_wr ? 1 : 0);
    @(posedge clk);
    #1;
    cyc++;
    chk("fifo_wren", 64'(fifo_wren), 64'(exp_wr));
    if (exp_wr) chk("fifo_wrdata", 64'(fifo_wrdata), 64'(exp_data));
    if (pend_hold) begin
      chk("hold_valid", 64'(dma_rdvalid), 64'd1);
      chk("hold_addr", 64'(dma_rdaddr), 64'(hold_addr));
    end
    if (fifo_wren) n_wr++;
    if (done) n_done++;
    dma_rddvalid = 1'b0;
    dma_rddata   = '0;
    if (resp_budget > 0 && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      dma_rddvalid = 1'b1;
      dma_rddata   = pend_data.pop_front();
      void'(pend_due.pop_front());
      resp_budget--;
    end
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [15:0] len, input logic circ);
    cfg_base     = base;
    cfg_len      = len;
    cfg_circular = circ;
    enable       = 1'b1;
    rec_addr.delete();
    n_acc  = 0;
    n_wr   = 0;
    n_done = 0;
    tick();
    // Scribble the config: it must be ignored until the next start.
    cfg_base     = 32'hDEAD_0000;
    cfg_len      = 16'd3;
    cfg_circular = ~circ;
  endtask

  task automatic finish_xfer(input string tag, input int bound);
    int k;
    for (k = 0; k < bound && !done; k++) tick();
    chk({tag, "_done"}, 64'(done), 64'd1);
    enable = 1'b0;
    tick();
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int k;
    for (k = 0; k < bound && busy; k++) tick();
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   bubbles;
    int   k;
    int   wr_before;
    logic [31:0] exp_a;

    vecs[0] = '{32'h0000_1000, 16'd8, 3, 32'h0000_101C};
    vecs[1] = '{32'hFFFF_FFF8, 16'd4, 3, 32'h0000_0004};
    vecs[2] = '{32'h0000_0040, 16'd1, 2, 32'h0000_0040};
    vecs[3] = '{32'h0000_0100, 16'd0, 3, 32'h0000_0000};
    vecs[4] = '{32'h0000_3000, 16'd6, 7, 32'h0000_3014};

    reset = 1'b1; enable = 1'b0; cfg_base = '0; cfg_len = '0; cfg_circular = 1'b0;
    dma_rdready = 1'b1; dma_rddata = '0; dma_rddvalid = 1'b0;
    fifo_full = 1'b0; fifo_afull = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_rdaddr", 64'(dma_rdaddr), 64'd0);
    chk("rst_rdvalid", 64'(dma_rdvalid), 64'd0);
    chk("rst_wren", 64'(fifo_wren), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    for (int v = 0; v < 5; v++) begin
      resp_lat = vecs[v].lat;
      start_xfer(vecs[v].base, vecs[v].len, 1'b0);
      chk("start_rdvalid", 64'(dma_rdvalid), 64'(vecs[v].len != 0));
      chk("start_done", 64'(done), 64'(vecs[v].len == 0));
      chk("start_busy", 64'(busy), 64'd1);
      if (vecs[v].len != 0) chk("start_rdaddr", 64'(dma_rdaddr), 64'(vecs[v].base));
      for (k = 0; k < 300 && !done; k++) tick();
      chk("tbl_done", 64'(done), 64'd1);
      chk("tbl_writes_at_done", 64'(n_wr), 64'(vecs[v].len));
      chk("tbl_accepts", 64'(n_acc), 64'(vecs[v].len));
      enable = 1'b0;
      tick();
      chk("tbl_busy_after_done", 64'(busy), 64'd0);
      chk("tbl_done_width", 64'(done), 64'd0);
      chk("tbl_done_count", 64'(n_done), 64'd1);
      for (int i = 0; i < rec_addr.size(); i++) begin
        exp_a = vecs[v].base + 32'(4 * i);
        chk("tbl_addr_seq", 64'(rec_addr[i]), 64'(exp_a));
      end
      if (rec_addr.size() > 0) chk("tbl_last_addr", 64'(rec_addr[$]), 64'(vecs[v].last));
    end

    // Outstanding limit with responses withheld, then released one at a time.
    resp_lat = 1; resp_budget = 0;
    start_xfer(32'h0000_5000, 16'd10, 1'b0);
    repeat (12) tick();
    chk("lim_accepts", 64'(n_acc), 64'd4);
    chk("lim_rdvalid", 64'(dma_rdvalid), 64'd0);
    resp_budget = 1;
    repeat (6) tick();
    chk("lim_accepts_after_one", 64'(n_acc), 64'd5);
    chk("lim_rdvalid_after_one", 64'(dma_rdvalid), 64'd0);
    chk("lim_writes_after_one", 64'(n_wr), 64'd1);
    resp_budget = 1000000;
    finish_xfer("lim", 100);
    chk("lim_total_accepts", 64'(n_acc), 64'd10);
    chk("lim_total_writes", 64'(n_wr), 64'd10);

    // Circular window: continuous requests across the wrap, never done.
    resp_lat = 3;
    start_xfer(32'h0000_2000, 16'd3, 1'b1);
    bubbles = 0;
    for (k = 0; k < 40 && n_acc < 10; k++) begin
      if (!dma_rdvalid) bubbles++;
      tick();
    end
    chk("circ_accepts", 64'(n_acc), 64'd10);
    chk("circ_bubbles", 64'(bubbles), 64'd0);
    for (int i = 0; i < 10; i++) begin
      exp_a = 32'h0000_2000 + 32'(4 * (i % 3));
      chk("circ_addr_seq", 64'(rec_addr[i]), 64'(exp_a));
    end
    enable = 1'b0;
    wait_idle("circ", 40);
    chk("circ_no_done", 64'(n_done), 64'd0);

    // Backpressure: afull blocks new requests, pending request held, overflow sticky.
    resp_lat = 2; dma_rdready = 1'b0;
    start_xfer(32'h0000_6000, 16'd4, 1'b0);
    fifo_afull = 1'b1; fifo_full = 1'b1;
    repeat (3) tick();
    chk("bp_hold_valid", 64'(dma_rdvalid), 64'd1);
    chk("bp_hold_addr", 64'(dma_rdaddr), 64'h6000);
    dma_rdready = 1'b1;
    tick();
    chk("bp_one_accept", 64'(n_acc), 64'd1);
    chk("bp_ovf_before", 64'(overflow), 64'd0);
    repeat (4) tick();
    chk("bp_no_new", 64'(dma_rdvalid), 64'd0);
    chk("bp_still_one", 64'(n_acc), 64'd1);
    chk("bp_overflow_set", 64'(overflow), 64'd1);
    fifo_full = 1'b0; fifo_afull = 1'b0;
    finish_xfer("bp", 100);
    chk("bp_accepts", 64'(n_acc), 64'd4);
    chk("bp_overflow_sticky", 64'(overflow), 64'd1);
    start_xfer(32'h0000_6100, 16'd1, 1'b0);
    chk("bp_overflow_cleared", 64'(overflow), 64'd0);
    finish_xfer("bp2", 50);

    // Abort: enable drops so the fifth accept is the last; two reads still in flight.
    resp_lat = 2;
    start_xfer(32'h0000_7000, 16'd16, 1'b0);
    for (k = 0; k < 20 && n_acc < 4; k++) tick();
    enable = 1'b0;
    tick();
    chk("abort_accepts", 64'(n_acc), 64'd5);
    chk("abort_writes_so_far", 64'(n_wr), 64'd3);
    chk("abort_rdvalid", 64'(dma_rdvalid), 64'd0);
    wait_idle("abort", 30);
    chk("abort_total_accepts", 64'(n_acc), 64'd5);
    chk("abort_total_writes", 64'(n_wr), 64'd5);
    chk("abort_no_done", 64'(n_done), 64'd0);

    // Reset mid-RUN: immediate reset values, late responses dropped.
    resp_lat = 3; fifo_full = 1'b1;
    start_xfer(32'h0000_8000, 16'd20, 1'b0);
    repeat (6) tick();
    chk("mid_overflow_pre", 64'(overflow), 64'd1);
    enable = 1'b0; reset = 1'b1;
    tick();
    chk("mid_rdaddr", 64'(dma_rdaddr), 64'd0);
    chk("mid_rdvalid", 64'(dma_rdvalid), 64'd0);
    chk("mid_wren", 64'(fifo_wren), 64'd0);
    chk("mid_wrdata", 64'(fifo_wrdata), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_overflow", 64'(overflow), 64'd0);
    reset = 1'b0; fifo_full = 1'b0;
    wr_before = n_wr;
    repeat (8) tick();
    chk("mid_late_dropped", 64'(n_wr), 64'(wr_before));
    chk("mid_still_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
